// File: rtl/phy_pkg.sv
// Shared lane definitions used by both transmit and receive lanes:
// comma symbol, lane byte width and the SYNC/ACTIVE state encoding.
package phy_pkg;

  localparam int LANE_W = 8;
  localparam logic [LANE_W-1:0] COM_SYMBOL_DEF = 8'hBC;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } lane_state_e;

endpackage

// File: rtl/phy_lane_serializer_ser_stats.sv
// Lane transmit statistics: wrapping 16-bit counts of data and comma slots.
// Only instantiated when SER_STATS_EN is defined.
module ser_stats (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        inc_data,
  input  logic        inc_com,
  output logic [15:0] data_bytes,
  output logic [15:0] com_bytes
);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      data_bytes <= '0;
      com_bytes  <= '0;
    end else begin
      if (inc_data) data_bytes <= data_bytes + 16'd1;
      if (inc_com)  com_bytes  <= com_bytes + 16'd1;
    end
  end

endmodule

// File: rtl/phy_lane_serializer.sv
// Per-lane 8:1 MSB-first transmit serializer with comma-based sync preamble.
// Define SER_STATS_EN to add the data_bytes/com_bytes statistics outputs.
//
// state     | meaning
// ST_SYNC   | sending comma bytes until SYNC_COUNT have gone out and enable is high
// ST_ACTIVE | sending the held byte at each slot, comma when nothing is held
module phy_lane_serializer
  import phy_pkg::*;
#(
  parameter logic [LANE_W-1:0] COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int                SYNC_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [LANE_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              enable,
  output logic              ready_out,
  output logic              data_out,
  output logic              active_out
`ifdef SER_STATS_EN
  ,
  output logic [15:0]       data_bytes,
  output logic [15:0]       com_bytes
`endif
);

  localparam logic [3:0] SYNC_MAX = 4'(SYNC_COUNT);

  lane_state_e       state, state_n;
  logic [LANE_W-1:0] sh, hold;
  logic [2:0]        bit_cnt;
  logic [3:0]        sync_cnt, sync_n;
  logic              hold_full, hold_full_n;
  logic              boundary, accept, load_hold;

  always_comb begin
    boundary  = (bit_cnt == 3'd7);
    accept    = valid_in && ready_out;
    state_n   = state;
    sync_n    = sync_cnt;
    load_hold = 1'b0;
    if (boundary) begin
      case (state)
        ST_SYNC: begin
          if (sync_cnt < SYNC_MAX) begin
            sync_n = sync_cnt + 4'd1;
          end else if (enable) begin
            state_n   = ST_ACTIVE;
            sync_n    = '0;
            load_hold = hold_full;
          end
        end
        default: begin
          // The byte in hold survives a resync and goes out once ACTIVE again.
          if (!enable) begin
            state_n = ST_SYNC;
            sync_n  = 4'd1;
          end else begin
            load_hold = hold_full;
          end
        end
      endcase
    end
    hold_full_n = (hold_full && !load_hold) || accept;
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sh         <= '0;
      bit_cnt    <= 3'd7;
      sync_cnt   <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      state      <= ST_SYNC;
      ready_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (boundary) sh <= load_hold ? hold : COM_SYMBOL;
      else          sh <= {sh[LANE_W-2:0], 1'b0};
      if (accept) hold <= data_in;
      hold_full  <= hold_full_n;
      state      <= state_n;
      sync_cnt   <= sync_n;
      active_out <= (state_n == ST_ACTIVE);
      ready_out  <= (state_n == ST_ACTIVE) && !hold_full_n;
    end
  end

  assign data_out = sh[LANE_W-1];

`ifdef SER_STATS_EN
  logic stat_com;
  assign stat_com = boundary && !load_hold &&
                    ((state == ST_ACTIVE) || (state_n == ST_ACTIVE));

  ser_stats u_stats (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .inc_data   (load_hold),
    .inc_com    (stat_com),
    .data_bytes (data_bytes),
    .com_bytes  (com_bytes)
  );
`endif

endmodule
